// File: rtl/bram_stream_ctrl.sv
// Streams rows through a simple-dual-port BRAM as a FIFO; read latency hidden by a small skid buffer.
// Latency: write to first o_rd_valid is RD_LAT+2 cycles; 1 row/cycle sustained; o_wr_ready drops at 2^ADDR_W rows in BRAM.
module bram_stream_ctrl #(
  parameter int DATA_W = 1028,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W+1:0] o_count,
  output logic              o_empty,
  output logic              o_cena,
  output logic              o_wea,
  output logic [ADDR_W-1:0] o_addra,
  output logic [DATA_W-1:0] o_dina,
  output logic              o_cenb,
  output logic [ADDR_W-1:0] o_addrb,
  input  logic [DATA_W-1:0] i_doutb
);

  localparam int SKID = RD_LAT + 1;
  localparam int SW   = $clog2(SKID + 2) + 1;
  localparam int IW   = (SKID > 1) ? $clog2(SKID) : 1;
  localparam int CW   = ADDR_W + 2;
  localparam logic [SW-1:0] SKID_C   = SW'(SKID);
  localparam logic [IW-1:0] LAST_IDX = IW'(SKID - 1);

  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   bram_cnt, bram_nxt;
  logic [RD_LAT-1:0] vld_sr;
  logic [SW-1:0]     skid_cnt, skid_nxt, inflight, inflight_nxt;
  logic [IW-1:0]     head, tail;
  logic [DATA_W-1:0] skid_mem [SKID];
  logic [CW-1:0]     count_q, count_nxt;
  logic              empty_q;
  logic              wr_ready, wr_en, rd_valid, pop, push, issue;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + SW'(vld_sr[i]);
    end
  end

  // Ready looks only at registered BRAM occupancy, so a same-cycle issue never unblocks a write.
  assign wr_ready = ~i_rst & ~bram_cnt[ADDR_W];
  assign wr_en    = i_wr_valid & wr_ready & ~i_clear;
  assign rd_valid = ~i_rst & (skid_cnt != '0);
  assign pop      = rd_valid & i_rd_ready;
  assign push     = vld_sr[RD_LAT-1];

  // Every issued read owns a skid slot, so the skid can never overflow.
  assign issue = ~i_rst & ~i_clear & (bram_cnt != '0) &
                 ((inflight + skid_cnt) < (SKID_C + SW'(pop)));

  assign bram_nxt     = bram_cnt + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(issue);
  assign inflight_nxt = inflight + SW'(issue) - SW'(push);
  assign skid_nxt     = skid_cnt + SW'(push) - SW'(pop);
  assign count_nxt    = CW'(bram_nxt) + CW'(inflight_nxt) + CW'(skid_nxt);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      wptr     <= '0;
      rptr     <= '0;
      bram_cnt <= '0;
      vld_sr   <= '0;
      skid_cnt <= '0;
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (issue) rptr <= rptr + 1'b1;
      bram_cnt <= bram_nxt;
      vld_sr   <= (vld_sr << 1) | RD_LAT'(issue);
      skid_cnt <= skid_nxt;
      if (push) tail <= (tail == LAST_IDX) ? '0 : tail + 1'b1;
      if (pop)  head <= (head == LAST_IDX) ? '0 : head + 1'b1;
      count_q  <= count_nxt;
      empty_q  <= (count_nxt == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_rst && !i_clear) skid_mem[tail] <= i_doutb;
  end

  assign o_wr_ready = wr_ready;
  assign o_cena     = wr_en;
  assign o_wea      = wr_en;
  assign o_addra    = wr_en ? wptr : '0;
  assign o_dina     = wr_en ? i_wr_data : '0;
  assign o_cenb     = issue;
  assign o_addrb    = issue ? rptr : '0;
  assign o_rd_valid = rd_valid;
  assign o_rd_data  = rd_valid ? skid_mem[head] : '0;
  assign o_count    = i_rst ? '0 : count_q;
  assign o_empty    = i_rst | empty_q;

endmodule

// File: tb/tb_bram_stream_ctrl.sv
// Directed + random bench for bram_stream_ctrl with a behavioural 2-cycle BRAM and a row scoreboard.
module tb_bram_stream_ctrl;
  localparam int DATA_W = 1028;
  localparam int ADDR_W = 8;
  typedef logic [DATA_W-1:0] row_t;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1, i_clear = 1'b0;
  logic              i_wr_valid = 1'b0, i_rd_ready = 1'b0;
  row_t              i_wr_data = '0;
  logic              o_wr_ready, o_rd_valid, o_empty, o_cena, o_wea, o_cenb;
  row_t              o_rd_data, o_dina, i_doutb;
  logic [ADDR_W+1:0] o_count;
  logic [ADDR_W-1:0] o_addra, o_addrb;

  int n_tests = 0, n_fail = 0, pop_cnt = 0;
  row_t q[$];
  row_t last_pop = '0, prev_dat = '0;
  logic stall_prev = 1'b0;

  always #5 clk = ~clk;

  bram_stream_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(2)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_clear(i_clear),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
    .o_count(o_count), .o_empty(o_empty),
    .o_cena(o_cena), .o_wea(o_wea), .o_addra(o_addra), .o_dina(o_dina),
    .o_cenb(o_cenb), .o_addrb(o_addrb), .i_doutb(i_doutb)
  );

  // BRAM model: data for a read issued in cycle t is on i_doutb in cycle t+2; garbage otherwise.
  row_t mem [1 << ADDR_W];
  row_t rd_p0 = '1, rd_p1 = '1;
  always @(posedge clk) begin
    if (o_cena && o_wea) mem[o_addra] <= o_dina;
    rd_p0 <= o_cenb ? mem[o_addrb] : '1;
    rd_p1 <= rd_p0;
  end
  assign i_doutb = rd_p1;

  task automatic chkv(input string tag, input row_t obs, input row_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    chk1("drain_done", q.size() == 0, 1'b1);
  endtask

  // Scoreboard: pushes accepted writes, pops on each read handshake, tracks count/empty/hold.
  always @(negedge clk) begin
    if (i_rst) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      chkv("count", row_t'(o_count), row_t'(q.size()));
      chk1("empty", o_empty, q.size() == 0);
      chk1("count_max", o_count <= 259, 1'b1);
      if (stall_prev) begin
        chk1("hold_vld", o_rd_valid, 1'b1);
        chkv("hold_dat", o_rd_data, prev_dat);
      end
      if (i_clear) begin
        q.delete();
      end else begin
        if (o_rd_valid && i_rd_ready) begin
          chk1("pop_nonempty", q.size() != 0, 1'b1);
          if (q.size() != 0) chkv("rd_data", o_rd_data, q.pop_front());
          pop_cnt++;
          last_pop = o_rd_data;
        end
        if (i_wr_valid && o_wr_ready) q.push_back(i_wr_data);
      end
      stall_prev = o_rd_valid && !i_rd_ready && !i_clear;
      prev_dat   = o_rd_data;
    end
  end

  task automatic run_flush(input logic use_rst);
    i_rd_ready = 1'b0;
    i_wr_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      i_wr_data = row_t'(200 + k);
      step();
    end
    i_wr_valid = 1'b0;
    repeat (4) step();
    i_rd_ready = 1'b1;
    step();
    step();
    i_rd_ready = 1'b0;
    i_wr_valid = 1'b1;
    i_wr_data  = row_t'(8'h77);
    if (use_rst) i_rst = 1'b1; else i_clear = 1'b1;
    @(negedge clk);
    if (use_rst) chk1("rst_wr_ready", o_wr_ready, 1'b0);
    else chkv("held_before_clear", row_t'(o_count), row_t'(10));
    step();
    i_rst = 1'b0;
    i_clear = 1'b0;
    i_wr_data = row_t'(8'h55);
    i_rd_ready = 1'b1;
    @(negedge clk);
    chkv("flush_count", row_t'(o_count), row_t'(0));
    chk1("flush_rd_valid", o_rd_valid, 1'b0);
    step();
    i_wr_valid = 1'b0;
    @(negedge clk);
    chk1("no_stale_1", o_rd_valid, 1'b0);
    step();
    @(negedge clk);
    chk1("no_stale_2", o_rd_valid, 1'b0);
    step();
    wait_drain(50);
    chkv("first_after_flush", last_pop, row_t'(8'h55));
  endtask

  initial begin
    int pb, acc, burst;
    logic wr_on;
    burst = 0;
    wr_on = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk1("rst_wr_ready", o_wr_ready, 1'b0);
    chk1("rst_empty", o_empty, 1'b1);
    chk1("rst_rd_valid", o_rd_valid, 1'b0);
    chk1("rst_cenb", o_cenb, 1'b0);
    chkv("rst_count", row_t'(o_count), row_t'(0));

    // Single row latency
    step();
    i_rst = 1'b0;
    i_wr_valid = 1'b1;
    i_wr_data = row_t'(12'hABC);
    i_rd_ready = 1'b1;
    @(negedge clk);
    chk1("c0_cena", o_cena, 1'b1);
    chk1("c0_wea", o_wea, 1'b1);
    chkv("c0_addra", row_t'(o_addra), row_t'(0));
    chkv("c0_dina", o_dina, row_t'(12'hABC));
    chk1("c0_cenb", o_cenb, 1'b0);
    step();
    i_wr_valid = 1'b0;
    @(negedge clk);
    chk1("c1_cenb", o_cenb, 1'b1);
    chkv("c1_addrb", row_t'(o_addrb), row_t'(0));
    chk1("c1_cena", o_cena, 1'b0);
    step();
    @(negedge clk);
    chk1("c2_rd_valid", o_rd_valid, 1'b0);
    step();
    @(negedge clk);
    chk1("c3_rd_valid", o_rd_valid, 1'b0);
    step();
    @(negedge clk);
    chk1("c4_rd_valid", o_rd_valid, 1'b1);
    chkv("c4_rd_data", o_rd_data, row_t'(12'hABC));
    step();
    @(negedge clk);
    chkv("c5_count", row_t'(o_count), row_t'(0));

    // 300-row stream, full throughput, pointer wrap
    step();
    pb = pop_cnt;
    for (int i = 0; i < 300; i++) begin
      i_wr_valid = 1'b1;
      i_wr_data = row_t'(i);
      step();
    end
    i_wr_valid = 1'b0;
    repeat (3) step();
    chkv("stream_299", row_t'(pop_cnt - pb), row_t'(299));
    step();
    chkv("stream_300", row_t'(pop_cnt - pb), row_t'(300));
    wait_drain(20);

    // Fill until full with downstream stalled
    pb = pop_cnt;
    i_rd_ready = 1'b0;
    i_wr_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 400; k++) begin
      i_wr_data = row_t'(1000 + acc);
      @(negedge clk);
      if (!o_wr_ready) break;
      acc++;
      step();
    end
    chkv("fill_accepted", row_t'(acc), row_t'(259));
    chkv("fill_count", row_t'(o_count), row_t'(259));

    // One pop at full: ready rises only the following cycle
    step();
    i_rd_ready = 1'b1;
    i_wr_data = row_t'(16'hF00D);
    @(negedge clk);
    chk1("full_pop_ready", o_wr_ready, 1'b0);
    chk1("full_pop_cenb", o_cenb, 1'b1);
    step();
    i_rd_ready = 1'b0;
    @(negedge clk);
    chk1("full_ready_rise", o_wr_ready, 1'b1);
    step();
    @(negedge clk);
    chk1("full_again", o_wr_ready, 1'b0);
    step();
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b1;
    wait_drain(600);
    chkv("full_last_row", last_pop, row_t'(16'hF00D));
    chkv("full_pops", row_t'(pop_cnt - pb), row_t'(260));
    chk1("full_drained_empty", o_empty, 1'b1);

    // Random backpressure with bursty writes
    for (int c = 0; c < 800; c++) begin
      i_rd_ready = 1'($urandom_range(0, 1));
      if (burst == 0) begin
        burst = $urandom_range(1, 8);
        wr_on = 1'($urandom_range(0, 1));
      end
      burst--;
      i_wr_valid = wr_on;
      i_wr_data = row_t'({$urandom, $urandom, $urandom});
      step();
    end
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b1;
    wait_drain(600);

    run_flush(1'b0);
    run_flush(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end
endmodule
